// File: rtl/score_scan_display.sv
// score_scan_display
//   Score / best-score tracker for the ball game with a multiplexed
//   seven-segment driver.
//   Goals add (hard ? 2*inc : inc) to a BCD score, one digit per cycle, and
//   then the score is compared against the best score. A lose pulse or a
//   stopped game clears the score. Both fields are scanned one digit per
//   SCAN_DIV cycles onto a shared select/segment bus.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   start         : level, game running
//   lose, goal    : single-cycle event pulses
//   hard          : level, double points
//   inc           : bar speed, sampled with goal
//   score_bcd     : current score, digit 0 in the LSBs
//   best_bcd      : best score
//   busy          : add/compare in progress
//   drop          : sticky, a goal was discarded
//   select        : one-hot digit enable (polarity from SEG_ACTIVE_LOW)
//   seg           : segments {g,f,e,d,c,b,a} (polarity from SEG_ACTIVE_LOW)
module score_scan_display #(
  parameter int SCORE_DIGITS   = 4,
  parameter int BEST_DIGITS    = 4,
  parameter int INC_W          = 4,
  parameter int SCAN_DIV       = 512,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 lose,
  input  logic                                 goal,
  input  logic                                 hard,
  input  logic [INC_W-1:0]                     inc,
  output logic [4*SCORE_DIGITS-1:0]            score_bcd,
  output logic [4*BEST_DIGITS-1:0]             best_bcd,
  output logic                                 busy,
  output logic                                 drop,
  output logic [SCORE_DIGITS+BEST_DIGITS-1:0]  select,
  output logic [6:0]                           seg
);

  localparam int N     = SCORE_DIGITS + BEST_DIGITS;
  localparam int SW    = 4 * SCORE_DIGITS;
  localparam int BW    = 4 * BEST_DIGITS;
  localparam int MW    = (SW > BW) ? SW : BW;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int IDX_W = $clog2(N);
  localparam int DIG_W = (SCORE_DIGITS > 1) ? $clog2(SCORE_DIGITS) : 1;

  localparam logic [SW-1:0] ALL9_S  = {SCORE_DIGITS{4'h9}};
  localparam logic [BW-1:0] ALL9_B  = {BEST_DIGITS{4'h9}};
  localparam logic [N-1:0]  SEL_OFF = (SEG_ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  localparam logic [6:0]    SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] d, input logic blank);
    logic [6:0] p;
    if (blank) begin
      p = 7'h00;
    end else begin
      case (d)
        4'd0:    p = 7'h3F;
        4'd1:    p = 7'h06;
        4'd2:    p = 7'h5B;
        4'd3:    p = 7'h4F;
        4'd4:    p = 7'h66;
        4'd5:    p = 7'h6D;
        4'd6:    p = 7'h7D;
        4'd7:    p = 7'h07;
        4'd8:    p = 7'h7F;
        4'd9:    p = 7'h6F;
        default: p = 7'h40;
      endcase
    end
    return p;
  endfunction

  // Binary 0..99 to two BCD digits {tens, ones}.
  function automatic logic [7:0] bin_to_bcd2(input logic [7:0] v);
    logic [7:0] tens;
    logic [7:0] ones;
    tens = v / 8'd10;
    ones = v - (tens * 8'd10);
    return {tens[3:0], ones[3:0]};
  endfunction

  state_t           state_q, state_d;
  logic [SW-1:0]    score_q, score_d;
  logic [SW-1:0]    acc_q, acc_d;
  logic [BW-1:0]    best_q, best_d;
  logic [7:0]       amt_q, amt_d;
  logic [DIG_W-1:0] dig_q, dig_d;
  logic             carry_q, carry_d;
  logic             pending_q, pending_d;
  logic             drop_q, drop_d;
  logic             busy_q, busy_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N-1:0]     select_q, select_d;
  logic [6:0]       seg_q, seg_d;

  logic             clear_s;
  logic [INC_W:0]   amt_raw_s;
  logic [7:0]       amt_bcd_s;
  logic [3:0]       cur_dig_s;
  logic [3:0]       addend_s;
  logic [4:0]       sum_s;
  logic [3:0]       new_dig_s;
  logic             carry_out_s;
  logic             overflow_s;
  logic             last_dig_s;
  logic [MW-1:0]    score_ext_s;
  logic [MW-1:0]    best_ext_s;
  logic             lz_s;
  logic [3:0]       disp_dig_s [N];
  logic             disp_blank_s [N];
  logic [N-1:0]     onehot_s;
  logic [6:0]       pat_s;

  // Clear condition and the BCD amount for a goal accepted this cycle.
  always_comb begin
    clear_s = lose | ~start;
    if (hard) begin
      amt_raw_s = {inc, 1'b0};
    end else begin
      amt_raw_s = {1'b0, inc};
    end
    amt_bcd_s = bin_to_bcd2(8'(amt_raw_s));
  end

  // One-digit decimal adder for the digit selected by dig_q.
  always_comb begin
    cur_dig_s = 4'd0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (dig_q == DIG_W'(i)) begin
        cur_dig_s = score_q[4*i +: 4];
      end else begin
        cur_dig_s = cur_dig_s;
      end
    end
    // Only the two lowest digits receive amount digits; higher ones just ripple the carry.
    if (dig_q == DIG_W'(0)) begin
      addend_s = amt_q[3:0];
    end else if (dig_q == DIG_W'(1)) begin
      addend_s = amt_q[7:4];
    end else begin
      addend_s = 4'd0;
    end
    sum_s = 5'(cur_dig_s) + 5'(addend_s) + 5'(carry_q);
    if (sum_s > 5'd9) begin
      new_dig_s   = 4'(sum_s - 5'd10);
      carry_out_s = 1'b1;
    end else begin
      new_dig_s   = sum_s[3:0];
      carry_out_s = 1'b0;
    end
    // A one-digit score cannot absorb a non-zero tens digit at all.
    overflow_s = carry_out_s | ((SCORE_DIGITS == 1) && (amt_q[7:4] != 4'd0));
    last_dig_s = (dig_q == DIG_W'(SCORE_DIGITS - 1));
    score_ext_s = MW'(score_q);
    best_ext_s  = MW'(best_q);
  end

  // Game FSM: accept goals, ripple the add through the digits, update best.
  always_comb begin
    state_d   = state_q;
    score_d   = score_q;
    acc_d     = acc_q;
    best_d    = best_q;
    amt_d     = amt_q;
    dig_d     = dig_q;
    carry_d   = carry_q;
    pending_d = pending_q;
    drop_d    = drop_q;
    if (clear_s) begin
      state_d   = IDLE;
      score_d   = {SW{1'b0}};
      pending_d = 1'b0;
      dig_d     = {DIG_W{1'b0}};
      carry_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (goal || pending_q) begin
            amt_d     = amt_bcd_s;
            dig_d     = {DIG_W{1'b0}};
            carry_d   = 1'b0;
            state_d   = ADD;
            // A goal arriving while a pending one is replayed becomes the new pending.
            pending_d = goal & pending_q;
          end else begin
            state_d = IDLE;
          end
        end
        ADD: begin
          for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (dig_q == DIG_W'(i)) begin
              acc_d[4*i +: 4] = new_dig_s;
            end else begin
              acc_d[4*i +: 4] = acc_q[4*i +: 4];
            end
          end
          carry_d = carry_out_s;
          // The score is published in one step once the top digit is done.
          if (last_dig_s) begin
            state_d = CMP;
            if (overflow_s) begin
              score_d = ALL9_S;
            end else begin
              score_d = acc_d;
            end
          end else begin
            dig_d = dig_q + DIG_W'(1);
          end
        end
        CMP: begin
          if (score_ext_s > best_ext_s) begin
            if (score_ext_s > MW'(ALL9_B)) begin
              best_d = ALL9_B;
            end else begin
              best_d = score_ext_s[BW-1:0];
            end
          end else begin
            best_d = best_q;
          end
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
      // Goals while busy: one deep pending slot, overflow is recorded as a drop.
      if (goal && (state_q != IDLE)) begin
        if (pending_q) begin
          drop_d = 1'b1;
        end else begin
          pending_d = 1'b1;
        end
      end else begin
        drop_d = drop_q;
      end
    end
    busy_d = (state_d != IDLE);
  end

  // Scan divider and digit index.
  always_comb begin
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = {DIV_W{1'b0}};
      if (idx_q == IDX_W'(N - 1)) begin
        idx_d = {IDX_W{1'b0}};
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
  end

  // Digit selection, leading-zero blanking and segment decode.
  always_comb begin
    lz_s = 1'b1;
    for (int i = SCORE_DIGITS - 1; i >= 0; i--) begin
      lz_s = lz_s & (score_q[4*i +: 4] == 4'd0);
      disp_dig_s[i]   = score_q[4*i +: 4];
      disp_blank_s[i] = (BLANK_LEADING != 0) && (i != 0) && lz_s;
    end
    lz_s = 1'b1;
    for (int i = BEST_DIGITS - 1; i >= 0; i--) begin
      lz_s = lz_s & (best_q[4*i +: 4] == 4'd0);
      disp_dig_s[SCORE_DIGITS + i]   = best_q[4*i +: 4];
      disp_blank_s[SCORE_DIGITS + i] = (BLANK_LEADING != 0) && (i != 0) && lz_s;
    end
    onehot_s = {{(N-1){1'b0}}, 1'b1} << idx_q;
    pat_s    = seg_decode(disp_dig_s[idx_q], disp_blank_s[idx_q]);
    if (SEG_ACTIVE_LOW != 0) begin
      select_d = ~onehot_s;
      seg_d    = ~pat_s;
    end else begin
      select_d = onehot_s;
      seg_d    = pat_s;
    end
  end

  // Game state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      score_q   <= {SW{1'b0}};
      acc_q     <= {SW{1'b0}};
      best_q    <= {BW{1'b0}};
      amt_q     <= 8'd0;
      dig_q     <= {DIG_W{1'b0}};
      carry_q   <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      score_q   <= score_d;
      acc_q     <= acc_d;
      best_q    <= best_d;
      amt_q     <= amt_d;
      dig_q     <= dig_d;
      carry_q   <= carry_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
      busy_q    <= busy_d;
    end
  end

  // Scan registers; select and seg share one register stage so they switch together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= {DIV_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      select_q <= SEL_OFF;
      seg_q    <= SEG_OFF;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      select_q <= select_d;
      seg_q    <= seg_d;
    end
  end

  assign score_bcd = score_q;
  assign best_bcd  = best_q;
  assign busy      = busy_q;
  assign drop      = drop_q;
  assign select    = select_q;
  assign seg       = seg_q;

endmodule

// File: doc/score_scan_display.md
Name: score_scan_display

Overview:
Parametrised score/best-score tracker and multiplexed seven-segment driver for the ball game. It accumulates the score in BCD on goal events, weighted by bar speed and difficulty, and clears the score on lose or game stop. It keeps a best score across games and time-multiplexes both fields onto a shared common-cathode/anode digit bus. All event handling is synchronous to one clock; no signal other than the reset is used as a clock or edge source.

Parameters:
SCORE_DIGITS, 4, BCD digits in score field (1..6)
BEST_DIGITS, 4, BCD digits in best field (1..6)
INC_W, 4, width of speed increment input (amount = inc or 2*inc, must be <= 99)
SCAN_DIV, 512, clk cycles per digit slot (>=2)
SEG_ACTIVE_LOW, 1, 1: seg/select low-active; 0: high-active
BLANK_LEADING, 1, 1: blank leading zeros in each field (digit 0 of each field is never blanked)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
start  in  1  level, 1 = game running
lose  in  1  single-cycle pulse, ball lost
goal  in  1  single-cycle pulse, ball hit
hard  in  1  level, 1 = double points
inc  in  INC_W  bar move speed, sampled with goal
score_bcd  out  4*SCORE_DIGITS  current score, digit 0 in LSBs
best_bcd  out  4*BEST_DIGITS  best score
busy  out  1  add/compare in progress
drop  out  1  sticky: a goal was discarded
select  out  SCORE_DIGITS+BEST_DIGITS  digit enables, one-hot (polarity per SEG_ACTIVE_LOW)
seg  out  7  segments {g,f,e,d,c,b,a}

Behaviour:
- Reset (async, rst=1): score, best, pending, drop = 0; FSM = IDLE; scan index 0, divider 0; select = all inactive; seg = all off; busy = 0.
- Clear condition: lose=1 or start=0. When asserted it clears score and pending and returns the FSM to IDLE, aborting any add in flight. best is retained. Clear has priority over goal in the same cycle.
- Amount: hard ? 2*inc : inc, converted to two BCD digits when goal is accepted.
- FSM states: IDLE, ADD, CMP.
  - IDLE: on goal (or pending=1), latch the amount, go to ADD, and clear pending.
  - ADD: one score digit per cycle, LSB first, with a decimal carry. After the top digit (SCORE_DIGITS cycles) go to CMP. If a carry leaves the top digit, score saturates to all 9s.
  - CMP: 1 cycle. If score > best (compared numerically over the wider field), best <= score, truncated/saturated to all 9s if BEST_DIGITS < SCORE_DIGITS. Then go to IDLE.
- busy = (state != IDLE). Goal-to-score-update latency = 1 + SCORE_DIGITS cycles; best updates 1 cycle later.
- Goal while busy: set pending (one deep). A goal while pending=1 is discarded and sets drop. drop is cleared only by rst.
- Scan: the divider counts 0..SCAN_DIV-1. On wrap, the index increments 0..N-1 and wraps, with N = SCORE_DIGITS+BEST_DIGITS.
  - Index i < SCORE_DIGITS shows score digit i. Otherwise it shows best digit i-SCORE_DIGITS.
  - select and seg are registered and update together, 1 cycle after the index change. There is no ghosting: both change in the same cycle.
- Decode (active-high form, bits g..a): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Blank = 00; a non-BCD code shows 40 (dash). Outputs are inverted when SEG_ACTIVE_LOW=1.
- Blanking: a digit is blank if BLANK_LEADING=1, it is not digit 0 of its field, and it and all higher digits of its field are 0.

Test Plan:
- Reset mid-scan, then release with start=1 -> select all inactive/seg off until first slot; score_bcd=0, best_bcd=0; digit 0 shows 0, others blank (SEG_ACTIVE_LOW=1: seg=7'h40 on slot0, 7'h7F elsewhere).
- start=1, hard=0, inc=7, 2 goals 10 cycles apart -> score_bcd=0x0014, best=0x0014; each update exactly 5 cycles after goal (SCORE_DIGITS=4).
- hard=1, inc=15, goal -> +30; then lose -> score 0, best holds 30 (0x0030); lose coincident with goal -> score 0, no add.
- 3 goals on consecutive cycles with inc=1 -> score=2, pending consumed, drop=1 sticky until rst.
- Preload score near 9990 via goals (inc=15, hard=1), further goal -> score saturates 9999, best 9999.
- Start deasserted during ADD -> FSM IDLE next cycle, score 0, busy 0, best unchanged.
